imem_boot_loader: RTL and testbench

- Sits upstream of the single-cycle RISC-V core and its instruction memory write port.
- Receives a byte stream (e.g. from a UART RX) framed as: 4-byte length, N little-endian 32-bit words, 1 checksum byte.
- Writes the words into instruction memory from word address 0.
- Holds the core in reset until the image is loaded and the checksum matches; then releases it.

---
 rtl/imem_boot_loader.sv | 135 +++++++++++++
 tb/tb_imem_boot_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory of the single-cycle core.
// Receives a byte stream framed as a 4-byte little-endian word count, that many
// little-endian 32-bit words, and one checksum byte (mod-256 sum of the data bytes).
// The words are written to instruction memory from word address 0. The core is held
// in reset until the whole image is in memory and the checksum matches.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_data/valid/ready    incoming byte stream, accepted when in_valid && in_ready
//   imem_we/addr/wdata     instruction-memory write port, one-cycle write pulse
//   core_rst               holds the core in reset while high
//   done                   image loaded and checksum good, core running
//   error                  length too large or checksum mismatch
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {StLen, StData, StCsum, StRun, StErr} state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic [7:0]            csum_q, csum_d;
  logic                  armed_q;
  logic                  imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [31:0]           imem_wdata_d;
  logic                  accept;
  logic [31:0]           len_full;
  logic                  last_word;

  // armed_q keeps in_ready low for the first cycle after reset is released.
  assign in_ready  = armed_q && (state_q inside {StLen, StData, StCsum});
  assign accept    = in_valid && in_ready;
  // Length as it will be once the current byte is shifted in (valid on the 4th byte).
  assign len_full  = {in_data, len_q[31:8]};
  assign last_word = (32'(word_cnt_q) == len_q - 32'd1);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    word_buf_d   = word_buf_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;

    if (accept) begin
      case (state_q)
        StLen: begin
          len_d      = len_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_full == 32'd0) begin
              state_d = StCsum;
            end else if (len_full > MAX_WORDS) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          csum_d     = csum_q + in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_buf_d = {in_data, word_buf_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q;
            imem_wdata_d = {in_data, word_buf_q};
            word_cnt_d   = word_cnt_q + ADDR_WIDTH'(1);
            if (last_word) begin
              state_d = StCsum;
            end
          end
        end
        StCsum: begin
          state_d = (in_data == csum_q) ? StRun : StErr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLen;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      word_buf_q <= '0;
      csum_q     <= '0;
      armed_q    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      word_buf_q <= word_buf_d;
      csum_q     <= csum_d;
      armed_q    <= 1'b1;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      // Status flags follow the state being entered on this edge.
      core_rst   <= (state_d != StRun);
      done       <= (state_d == StRun);
      error      <= (state_d == StErr);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  localparam int unsigned AW = 10;
  localparam int unsigned MW = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  // Current image under test and the frame built from it.
  logic [31:0] words[$];
  logic [7:0]  frame[$];
  logic [31:0] len_field;
  bit          exp_ok;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_WIDTH(AW),
    .MAX_WORDS (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame = length bytes, data bytes, checksum (+ delta to corrupt it).
  // An oversize length stops the frame after the length bytes.
  task automatic make_frame(input logic [31:0] len, input logic [7:0] csum_delta);
    logic [7:0]  sum;
    logic [31:0] wv;
    sum = 8'd0;
    frame.delete();
    len_field = len;
    for (int i = 0; i < 4; i++) frame.push_back(len[8*i +: 8]);
    if (len > MW) begin
      exp_ok = 1'b0;
      return;
    end
    for (int w = 0; w < words.size(); w++) begin
      wv = words[w];
      for (int b = 0; b < 4; b++) begin
        frame.push_back(wv[8*b +: 8]);
        sum += wv[8*b +: 8];
      end
    end
    frame.push_back(sum + csum_delta);
    exp_ok = (csum_delta == 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rises", 32'(in_ready), 32'd1);
  endtask

  // stall_pct < 0 toggles in_valid every cycle; otherwise random stalls.
  task automatic run_frame(input string name, input int stall_pct, input int stop_after);
    int idx;
    int prev_k;
    int n;
    int cyc;
    int w;
    bit fin;
    idx    = 0;
    prev_k = -1;
    cyc    = 0;
    n      = (stop_after < frame.size()) ? stop_after : frame.size();
    forever begin
      @(negedge clk);
      // Outputs produced by the previous edge.
      if (len_field <= MW && prev_k >= 4 && prev_k < 4 + 4 * int'(len_field) &&
          ((prev_k - 4) % 4) == 3) begin
        w = (prev_k - 4) / 4;
        check($sformatf("%s_we_w%0d", name, w), 32'(imem_we), 32'd1);
        check($sformatf("%s_addr_w%0d", name, w), 32'(imem_addr), 32'(w));
        check($sformatf("%s_data_w%0d", name, w), imem_wdata, words[w]);
      end else begin
        check($sformatf("%s_we_idle", name), 32'(imem_we), 32'd0);
      end
      fin = (idx == frame.size());
      check($sformatf("%s_done", name), 32'(done), 32'(fin && exp_ok));
      check($sformatf("%s_error", name), 32'(error), 32'(fin && !exp_ok));
      check($sformatf("%s_core_rst", name), 32'(core_rst), 32'(!(fin && exp_ok)));
      check($sformatf("%s_in_ready", name), 32'(in_ready), 32'(!fin));
      if (idx >= n || cyc > 20000) break;
      if (stall_pct < 0) in_valid = cyc[0];
      else in_valid = ($urandom_range(99) >= 32'(stall_pct));
      in_data = in_valid ? frame[idx] : 8'($urandom);
      cyc++;
      #1;
      if (in_valid && in_ready) begin
        prev_k = idx;
        idx++;
      end else begin
        prev_k = -1;
      end
    end
    in_valid = 1'b0;
    if (idx < n) check($sformatf("%s_timeout", name), 32'(idx), 32'(n));
    if (n == frame.size()) begin
      // Further bytes are ignored once the loader has decided.
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        check($sformatf("%s_post_we", name), 32'(imem_we), 32'd0);
        check($sformatf("%s_post_ready", name), 32'(in_ready), 32'd0);
        check($sformatf("%s_post_done", name), 32'(done), 32'(exp_ok));
        check($sformatf("%s_post_error", name), 32'(error), 32'(!exp_ok));
      end
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int nw;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;

    do_reset();
    words = '{32'h00500093, 32'h00100113};
    make_frame(32'd2, 8'd0);
    run_frame("nominal", 0, 1 << 30);

    do_reset();
    make_frame(32'd2, 8'd1);
    run_frame("bad_csum", 0, 1 << 30);

    do_reset();
    words.delete();
    make_frame(32'd0, 8'd0);
    run_frame("zero_len", 0, 1 << 30);

    do_reset();
    make_frame(32'd1025, 8'd0);
    run_frame("oversize", 0, 1 << 30);

    do_reset();
    words = '{32'h00500093, 32'h00100113};
    make_frame(32'd2, 8'd0);
    run_frame("toggle", -1, 1 << 30);

    // Reset after word 0 is written, then reload a one-word image.
    do_reset();
    run_frame("midload", 0, 8);
    do_reset();
    words = '{32'hAABBCCDD};
    make_frame(32'd1, 8'd0);
    run_frame("reload", 30, 1 << 30);

    // Largest accepted image: last address is 2**AW-1, no wrap.
    do_reset();
    words.delete();
    for (int i = 0; i < int'(MW); i++) words.push_back($urandom);
    make_frame(MW, 8'd0);
    run_frame("max_len", 0, 1 << 30);

    for (int t = 0; t < 20; t++) begin
      do_reset();
      words.delete();
      nw = $urandom_range(0, 6);
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      make_frame(32'(nw), ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      run_frame($sformatf("rand%0d", t), $urandom_range(0, 60), 1 << 30);
    end

    do_reset();
    words.delete();
    make_frame(32'd1025 + $urandom_range(0, 32'h7fff_0000), 8'd0);
    run_frame("rand_oversize", 20, 1 << 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
